// File: rtl/even_parity_uart_tx.sv
// Even-parity UART transmitter: start bit, DATA_W data bits (LSB first), parity bit, stop bit(s).
// Define EVEN_PARITY_UART_TX_TWO_STOP_EN for two stop bits; otherwise one stop bit is sent.
module even_parity_uart_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_o,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef EVEN_PARITY_UART_TX_TWO_STOP_EN
    localparam int unsigned STOP_BITS = 2;
`else
    localparam int unsigned STOP_BITS = 1;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] DATA_LAST   = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST   = IDX_W'(STOP_BITS - 1);
    localparam bit ONE_CLK           = (CLKS_PER_BIT == 1);
    localparam bit DONE_ON_STOP_ENTRY = ONE_CLK && (STOP_BITS == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shift_q;
    logic               parity_q;

    logic bit_tick_c;
    logic stop_end_c;
    logic accept_c;

    // A new word is taken in IDLE or on the edge that closes the last stop bit (gapless chaining).
    assign bit_tick_c = (bit_cnt == CNT_LAST);
    assign stop_end_c = (state == STOP) && bit_tick_c && (bit_idx == STOP_LAST);
    assign accept_c   = in_valid && ((state == IDLE) || stop_end_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_o     <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (accept_c) begin
            state    <= START;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift_q  <= in_data;
            parity_q <= ^in_data;
            tx_o     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_o     <= 1'b1;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                START: begin
                    if (bit_tick_c) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_o    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_tick_c) begin
                        bit_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            state <= PARITY;
                            tx_o  <= parity_q;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx_o    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_tick_c) begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_o    <= 1'b1;
                        done    <= DONE_ON_STOP_ENTRY;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    // done is raised one edge early so it lands on the final stop cycle.
                    if (bit_tick_c) begin
                        if (bit_idx == STOP_LAST) begin
                            state    <= IDLE;
                            bit_cnt  <= '0;
                            bit_idx  <= '0;
                            tx_o     <= 1'b1;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            bit_cnt <= '0;
                            bit_idx <= bit_idx + IDX_W'(1);
                            done    <= ONE_CLK && ((bit_idx + IDX_W'(1)) == STOP_LAST);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        done    <= (bit_cnt == CNT_PRELAST) && (bit_idx == STOP_LAST);
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_o     <= 1'b1;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
